// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM encoding and the default baud divisor.
// The receiver imports this today; the future transmitter imports the same package.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // 50 MHz system clock divided down to 115200 baud
  localparam int CLK_PER_BIT_115200 = 434;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t ST_IDLE      = 3'd0;
  localparam rx_state_t ST_START     = 3'd1;
  localparam rx_state_t ST_DATA      = 3'd2;
  localparam rx_state_t ST_PARITY    = 3'd3;
  localparam rx_state_t ST_STOP      = 3'd4;
  localparam rx_state_t ST_WAIT_HIGH = 3'd5;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Receiver-side bundle: raw serial pin into the receiver, received word and status out.
interface uart_rx_frame_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  uart_rx_pin;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_parity_err;
  logic                  rx_frame_err;
  logic                  rx_busy;

  modport master (
    input  uart_rx_pin,
    output rx_data,
    output rx_valid,
    output rx_parity_err,
    output rx_frame_err,
    output rx_busy
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input rx_parity_err,
    input rx_frame_err,
    input rx_busy
  );

endinterface

// File: rtl/uart_bit_sampler.sv
// Front end of the receiver: two-flop synchroniser, falling-edge detect and a
// 3-sample majority vote around the middle of each bit period.
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_115200,
  parameter int CNT_W       = $clog2(CLK_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pin,
  input  logic [CNT_W-1:0] clk_cnt,
  output logic             rxs,
  output logic             fall,
  output logic             bit_value
);

  localparam int H = CLK_PER_BIT / 2;
  localparam logic [CNT_W-1:0] CNT_SAMPLE0 = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE1 = CNT_W'(H);

  logic sync1;
  logic sync2;
  logic rxs_prev;
  logic samp0;
  logic samp1;

  // Flops reset high so an idle line never looks like a start edge after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      sync1    <= pin;
      sync2    <= sync1;
      rxs_prev <= sync2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp0 <= 1'b1;
      samp1 <= 1'b1;
    end else begin
      if (clk_cnt == CNT_SAMPLE0) samp0 <= sync2;
      if (clk_cnt == CNT_SAMPLE1) samp1 <= sync2;
    end
  end

  // Third vote is the live sample, so the decision is valid while clk_cnt = H+1
  assign rxs       = sync2;
  assign fall      = rxs_prev & ~sync2;
  assign bit_value = majority3(samp0, samp1, sync2);

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: configurable width, optional odd/even parity, 1 or 2 stop bits,
// false-start rejection and parity/framing error flags delivered with a one-cycle strobe.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_115200,
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_MODE = PARITY_NONE,
  parameter int STOP_BITS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_frame_if.master bus
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam int H     = CLK_PER_BIT / 2;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(H + 1);
  localparam logic [BIT_W-1:0] LAST_DATA  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] LAST_STOP  = BIT_W'(STOP_BITS - 1);
  localparam logic HAS_PARITY = (PARITY_MODE != PARITY_NONE);
  localparam logic ODD_PARITY = (PARITY_MODE == PARITY_ODD);

  rx_state_t             state;
  logic [CNT_W-1:0]      clk_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_err;
  logic                  frm_err;

  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  perr_q;
  logic                  ferr_q;

  logic rxs;
  logic fall;
  logic bit_value;
  logic decide;

  uart_bit_sampler #(
    .CLK_PER_BIT (CLK_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .pin       (bus.uart_rx_pin),
    .clk_cnt   (clk_cnt),
    .rxs       (rxs),
    .fall      (fall),
    .bit_value (bit_value)
  );

  assign decide = (state != ST_IDLE) && (clk_cnt == CNT_DECIDE);

  // Bit timer restarts on the start edge so every later bit is timed from it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_cnt <= '0;
    end else if (state == ST_IDLE || state == ST_WAIT_HIGH) begin
      clk_cnt <= '0;
    end else if (clk_cnt == CNT_LAST) begin
      clk_cnt <= '0;
    end else begin
      clk_cnt <= clk_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_err   <= 1'b0;
      frm_err   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fall) begin
            state   <= ST_START;
            bit_cnt <= '0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
          end
        end
        ST_START: begin
          if (decide) state <= bit_value ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (decide) begin
            shift_reg <= {bit_value, shift_reg[DATA_WIDTH-1:1]};
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              state   <= HAS_PARITY ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (decide) begin
            par_err <= bit_value ^ (^shift_reg) ^ ODD_PARITY;
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Leaving mid-stop-bit lets a start edge right after the stop bit be caught
          if (decide) begin
            if (bit_cnt == LAST_STOP) begin
              valid_q <= 1'b1;
              data_q  <= shift_reg;
              perr_q  <= par_err;
              ferr_q  <= frm_err | ~bit_value;
              state   <= bit_value ? ST_IDLE : ST_WAIT_HIGH;
            end else begin
              frm_err <= frm_err | ~bit_value;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_WAIT_HIGH: begin
          if (rxs) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rx_data       = data_q;
  assign bus.rx_valid      = valid_q;
  assign bus.rx_parity_err = perr_q;
  assign bus.rx_frame_err  = ferr_q;
  assign bus.rx_busy       = (state != ST_IDLE);

endmodule
